// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and types for the instruction memory
package imem_pkg;

  localparam int IMEM_ADDR_W = 9;
  localparam int IMEM_DEPTH  = 512;
  localparam int INSTR_W     = 32;
  localparam int BYTE_W      = 8;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/imem_align_chk.sv
// rtl/imem_align_chk.sv - sticky misaligned-fetch flag register
module imem_align_chk (
  input  logic clk,
  input  logic reset,
  input  logic misaligned,
  output logic flag
);

  // Set on any misaligned fetch, held until reset; reset wins over set.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag <= 1'b0;
    end else if (misaligned) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// rtl/instruction_memory.sv - big-endian byte-addressed instruction memory (optional IMEM_ALIGN_CHECK_EN)
module instruction_memory
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] A,
  output instr_t            I,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [31:0]       wd,
  output logic              align_err
);

  // One byte per entry so a byte-per-line preload lands at index 0 upward.
  logic [BYTE_W-1:0] mem [DEPTH];

  // DEPTH equals 2**ADDR_W, so plain ADDR_W-bit addition wraps modulo DEPTH.
  logic [ADDR_W-1:0] ra1, ra2, ra3;
  logic [ADDR_W-1:0] wa1, wa2, wa3;

  assign ra1 = A + ADDR_W'(1);
  assign ra2 = A + ADDR_W'(2);
  assign ra3 = A + ADDR_W'(3);

  assign wa1 = wa + ADDR_W'(1);
  assign wa2 = wa + ADDR_W'(2);
  assign wa3 = wa + ADDR_W'(3);

  // Combinational big-endian read; the lowest address is the most significant byte.
  assign I = {mem[A], mem[ra1], mem[ra2], mem[ra3]};

  // Word write split into byte lanes; reset blocks the write but never clears contents.
  always_ff @(posedge clk) begin
    if (!reset && we) begin
      mem[wa]  <= wd[31:24];
      mem[wa1] <= wd[23:16];
      mem[wa2] <= wd[15:8];
      mem[wa3] <= wd[7:0];
    end
  end

`ifdef IMEM_ALIGN_CHECK_EN
  imem_align_chk u_align_chk (
    .clk        (clk),
    .reset      (reset),
    .misaligned (A[1:0] != 2'b00),
    .flag       (align_err)
  );
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_memory.sv
// tb/tb_instruction_memory.sv - scoreboard bench for instruction_memory
module tb_instruction_memory;

  import imem_pkg::*;

`ifdef IMEM_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [8:0]  A;
  instr_t      I;
  logic        we;
  logic [8:0]  wa;
  logic [31:0] wd;
  logic        align_err;

  instruction_memory dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .I         (I),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .align_err (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] exp;
    logic        is_flag;
    logic [7:0]  tag;
  } exp_t;

  exp_t q[$];
  int   tests;
  int   fails;

  logic [31:0] prog [13];

  // Scoreboard monitor: everything queued since the last negedge is checked here.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = q.pop_front();
      act = e.is_flag ? {31'd0, align_err} : I;
      tests++;
      if (act !== e.exp) begin
        fails++;
        $display("FAIL %s #%0d: got %h, expected %h",
                 e.is_flag ? "align_err" : "I", e.tag, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_i(input logic [7:0] tag, input logic [31:0] v);
    q.push_back('{exp: v, is_flag: 1'b0, tag: tag});
  endtask

  task automatic exp_f(input logic [7:0] tag, input logic v);
    q.push_back('{exp: {31'd0, v}, is_flag: 1'b1, tag: tag});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    prog[0]  = 32'h8C010004;
    prog[1]  = 32'h8C020008;
    prog[2]  = 32'h00221820;
    prog[3]  = 32'hAC03000C;
    prog[4]  = 32'h10000002;
    prog[5]  = 32'h20040005;
    prog[6]  = 32'h00852022;
    prog[7]  = 32'h08000000;
    prog[8]  = 32'h3C05ABCD;
    prog[9]  = 32'h34A51234;
    prog[10] = 32'h00A62825;
    prog[11] = 32'h0000000C;
    prog[12] = 32'hFFFFFFFF;

    reset = 1'b1;
    A     = 9'd0;
    we    = 1'b0;
    wa    = 9'd0;
    wd    = 32'd0;
    step();
    step();
    exp_f(8'd0, 1'b0);
    step();
    reset = 1'b0;

    for (int k = 0; k < 13; k++) begin
      we = 1'b1;
      wa = 9'(4 * k);
      wd = prog[k];
      step();
    end
    we = 1'b0;

    for (int k = 0; k < 13; k++) begin
      A = 9'(4 * k);
      exp_i(8'(10 + k), prog[k]);
      step();
    end

    A = 9'd2;
    exp_i(8'd30, 32'h00048C02);
    step();

    we = 1'b1; wa = 9'd16; wd = 32'hDEADBEEF;
    step();
    we = 1'b0;
    A = 9'd16;
    exp_i(8'd31, 32'hDEADBEEF);
    step();
    A = 9'd17;
    exp_i(8'd32, 32'hADBEEF20);
    step();

    we = 1'b1; wa = 9'd510; wd = 32'h11223344;
    step();
    we = 1'b0;
    A = 9'd510;
    exp_i(8'd33, 32'h11223344);
    step();
    A = 9'd0;
    exp_i(8'd34, 32'h33440004);
    step();
    A = 9'd511;
    exp_i(8'd35, 32'h22334400);
    step();

    A = 9'd8; we = 1'b1; wa = 9'd8; wd = 32'hCAFEF00D;
    exp_i(8'd36, 32'h00221820);
    step();
    we = 1'b0;
    exp_i(8'd37, 32'hCAFEF00D);
    step();

    A = 9'd0; reset = 1'b1; we = 1'b1; wa = 9'd0; wd = 32'hFFFFFFFF;
    step();
    reset = 1'b0; we = 1'b0;
    exp_i(8'd38, 32'h33440004);
    exp_f(8'd39, 1'b0);
    step();

    A = 9'd6;
    exp_f(8'd40, 1'b0);
    exp_i(8'd41, 32'h0008CAFE);
    step();
    A = 9'd8;
    exp_f(8'd42, ALIGN_EN);
    step();
    exp_f(8'd43, ALIGN_EN);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_f(8'd44, 1'b0);
    exp_i(8'd45, 32'hCAFEF00D);
    step();
    step();

    A = 9'd0;
    #1;
    tests++;
    if (I !== 32'h33440004) begin
      fails++;
      $display("FAIL I #50: got %h, expected %h", I, 32'h33440004);
    end
    A = 9'd16;
    #1;
    tests++;
    if (I !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL I #51: got %h, expected %h", I, 32'hDEADBEEF);
    end
    A = 9'd510;
    #1;
    tests++;
    if (I !== 32'h11223344) begin
      fails++;
      $display("FAIL I #52: got %h, expected %h", I, 32'h11223344);
    end
    tests++;
    if (align_err !== 1'b0) begin
      fails++;
      $display("FAIL align_err #53: got %b, expected 0", align_err);
    end
    A = 9'd8;
    #1;
    tests++;
    if (I !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL I #54: got %h, expected %h", I, 32'hCAFEF00D);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
